// File: rtl/add_req_initiator.sv
// Initiator for a one-cycle-latency adder: takes operand pairs from a valid/ready
// stream, issues them as start pulses, checks the adder result and returns it downstream.
module add_req_initiator #(
    parameter int W       = 16,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             start,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    input  logic             valid,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_mismatch,
    output logic             out_err,
    output logic             proto_err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      exp_r;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [W-1:0]      out_sum_r;
    logic              out_mismatch_r;
    logic              out_err_r;
    logic              proto_err_r;
    logic [CNT_W-1:0]  issued_cnt_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic              in_ready_s;
    logic              start_s;
    logic              out_valid_s;
    logic              handshake_s;
    logic              wait_last_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign handshake_s = in_valid & in_ready_s;
    assign wait_last_s = (wait_cnt_r == WAIT_LAST);

    // State register; async reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a valid arriving on the final WAIT cycle still wins over timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (valid || wait_last_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; in_ready is gated by rst_n so it is low throughout reset.
    always_comb begin
        in_ready_s  = 1'b0;
        start_s     = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = rst_n;
            ISSUE:   start_s     = 1'b1;
            WAIT:    out_valid_s = 1'b0;
            RESP:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Operand capture and expected-sum precomputation on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
            exp_r <= {W{1'b0}};
        end else if (handshake_s) begin
            a_r   <= in_a;
            b_r   <= in_b;
            exp_r <= in_a + in_b;
        end
    end

    // Wait counter: cleared on issue, advanced each WAIT cycle without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if ((state_r == WAIT) && !valid && !wait_last_s) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1'b1);
        end
    end

    // Response capture; values stay frozen through RESP until the next WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum_r      <= {W{1'b0}};
            out_mismatch_r <= 1'b0;
            out_err_r      <= 1'b0;
        end else if ((state_r == WAIT) && valid) begin
            out_sum_r      <= y;
            out_mismatch_r <= (y != exp_r);
            out_err_r      <= 1'b0;
        end else if ((state_r == WAIT) && wait_last_s) begin
            out_sum_r      <= {W{1'b0}};
            out_mismatch_r <= 1'b0;
            out_err_r      <= 1'b1;
        end
    end

    // Status: sticky protocol error and saturating issue/error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r  <= 1'b0;
            issued_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (valid && (state_r != WAIT)) begin
                proto_err_r <= 1'b1;
            end
            if (state_r == ISSUE) begin
                issued_cnt_r <= sat_inc(issued_cnt_r);
            end
            if ((state_r == WAIT) &&
                ((valid && (y != exp_r)) || (!valid && wait_last_s))) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign start        = start_s;
    assign a            = a_r;
    assign b            = b_r;
    assign out_valid    = out_valid_s;
    assign out_sum      = out_sum_r;
    assign out_mismatch = out_mismatch_r;
    assign out_err      = out_err_r;
    assign proto_err    = proto_err_r;
    assign issued_cnt   = issued_cnt_r;
    assign err_cnt      = err_cnt_r;

endmodule

// File: doc/add_req_initiator.md
# add_req_initiator

Initiator for the one-cycle-latency adder handshake (start/a/b in, valid/y out). It accepts operand pairs from an upstream valid/ready stream and issues each pair to the adder as a single-cycle start pulse. It then waits for valid with a bounded timeout, checks y against its own W-bit sum, and presents the result downstream on a valid/ready stream. It sits between an operand source (sequencer or CPU-side queue) and the adder, and keeps issue and error counters for status.

## Interface
- W, 16, operand/result width
- TIMEOUT, 8, maximum WAIT cycles for valid before timeout (≥1)
- CNT_W, 16, width of status counters
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  initiator can accept a pair
- in_a  in  W  operand A
- in_b  in  W  operand B
- start  out  1  one-cycle issue pulse to adder
- a  out  W  operand A to adder (registered)
- b  out  W  operand B to adder (registered)
- valid  in  1  adder result valid
- y  in  W  adder result
- out_valid  out  1  result available downstream
- out_ready  in  1  downstream accepts result
- out_sum  out  W  captured y (0 on timeout)
- out_mismatch  out  1  y != (a+b) mod 2^W
- out_err  out  1  timeout, no valid received
- proto_err  out  1  sticky: valid seen outside WAIT
- issued_cnt  out  CNT_W  starts issued, saturating
- err_cnt  out  CNT_W  responses with mismatch or timeout, saturating

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, register in_a→a and in_b→b, register exp=(in_a+in_b) truncated to W bits, and go to ISSUE.
- ISSUE: start=1 for exactly this cycle. issued_cnt+1. Go to WAIT and clear wait counter.
- WAIT: if valid=1, capture y→out_sum, set out_mismatch=(y!=exp), clear out_err, and go to RESP. Else if wait counter==TIMEOUT-1, set out_sum=0, out_mismatch=0, out_err=1, and go to RESP. Else increment the wait counter.
- valid and the timeout condition in the same cycle: valid wins, no error.
- RESP: out_valid=1, with out_sum/out_mismatch/out_err held stable. err_cnt+1 on entry if mismatch or timeout. On out_ready go to IDLE.
- valid=1 in IDLE, ISSUE or RESP sets proto_err. proto_err clears only on reset; the stray valid is otherwise ignored.
- in_ready=0 in ISSUE, WAIT and RESP. One operation is in flight at a time.
- a/b hold the last issued operands after issue.
- Counters saturate at all-ones and never wrap.
- Reset values: start=0, a=0, b=0, in_ready=0 while rst_n=0, out_valid=0, out_sum=0, out_mismatch=0, out_err=0, proto_err=0, issued_cnt=0, err_cnt=0, FSM=IDLE.
- Reset mid-operation aborts the in-flight op with no response. After rst_n rises, in_ready=1 from the first cycle.

## Timing
- Cycle 0: in handshake in IDLE.
- Cycle 1: start=1, with a/b valid the same cycle.
- Cycle 2: first WAIT cycle. A one-cycle-latency adder asserts valid here.
- Cycle 3: out_valid=1 with the result.
- Minimum issue-to-issue spacing is 4 cycles (IDLE→ISSUE→WAIT→RESP with out_ready=1).
- Timeout: WAIT spans at most TIMEOUT cycles (cycles 2..TIMEOUT+1), and out_valid with out_err rises at cycle TIMEOUT+2. With TIMEOUT=8 that is cycle 10.
- out_valid, out_sum and the flags must not change while out_valid=1 and out_ready=0.
- Asynchronous reset: start and out_valid drop immediately on the rst_n falling edge.

## Test plan
- Single op: a=0x0003, b=0x0004, adder latency 1 → start high only in cycle 1; out_valid in cycle 3 with out_sum=0x0007, out_mismatch=0, out_err=0; issued_cnt=1, err_cnt=0.
- Wrap-around: a=0xFFFF, b=0x0002 → out_sum=0x0001, out_mismatch=0.
- Adder never asserts valid, TIMEOUT=8 → out_valid in cycle 10, out_err=1, out_sum=0x0000, err_cnt=1. Second case: valid at the last WAIT cycle (cycle 9) → out_err=0.
- Faulty adder returns y=0x1234 for a=1, b=1 → out_sum=0x1234, out_mismatch=1, err_cnt increments.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → outputs stable, in_ready=0, no second start. On out_ready=1, next pair accepted the following cycle, with start one cycle later.
- rst_n low during WAIT → start=0 and out_valid=0 immediately, counters=0, in_ready=1 on the first cycle after release. Stray valid pulse in IDLE → proto_err=1 and stays 1 until reset.
